shared_adder_sequencer: RTL and testbench

//  Shares one 4-bit ripple adder slice between two requesters and sequences it

---
 rtl/shared_adder_pkg.sv | 17 +
 rtl/nibble_add4.sv | 16 +
 rtl/shared_adder_sequencer.sv | 138 +++++++++++++
 tb/tb_shared_adder_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_adder_pkg.sv
// Shared definitions for the nibble-serial shared adder.
//   NIBBLE_W : width of the single adder slice
//   state_t  : sequencer states
//   req_id_t : requester index
package shared_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit adder slice.
//   a, b : nibble operands
//   cin  : carry in
//   s    : nibble sum
//   cout : carry out
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/shared_adder_sequencer.sv
// Two requesters share one 4-bit adder slice, which is stepped nibble by
// nibble (LSB first) to add WIDTH-bit operands, with a registered carry.
// Round-robin arbitration; valid/ready handshakes on both sides.
//   clk, rst_n            : clock, async active-low reset
//   reqN_valid/ready      : request handshake for requester N (0/1)
//   reqN_a, reqN_b, cin   : operands and carry-in of requester N
//   rsp_valid/ready       : response handshake
//   rsp_id                : requester that owns the result
//   rsp_sum, rsp_cout     : (A+B+cin) mod 2^WIDTH and carry out
//   busy                  : operation in flight (CALC or DONE)
module shared_adder_sequencer
    import shared_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             busy
);

    localparam int NIB  = WIDTH / NIBBLE_W;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    req_id_t           rr_q;      // last requester served
    req_id_t           id_q;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic              cout_q;

    req_id_t           grant_id;
    logic              accept;
    logic [3:0]        nib_a, nib_b, nib_s;
    logic              nib_c;
    logic              last_pass;

    // Tie goes to the requester not served last; otherwise the sole valid one.
    always_comb begin
        grant_id = req_id_t'(req1_valid);
        if (req0_valid && req1_valid) begin
            grant_id = ~rr_q;
        end
    end

    // Ready is gated by rst_n so it drops immediately when reset is asserted.
    assign accept     = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && (grant_id == 1'b0);
    assign req1_ready = accept && (grant_id == 1'b1);

    assign nib_a     = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nib_b     = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign last_pass = (idx_q == LAST_IDX);

    nibble_add4 u_add (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_c)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = CALC;
            CALC:    if (last_pass) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            rr_q    <= 1'b1;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= grant_id ? req1_a   : req0_a;
                        b_q     <= grant_id ? req1_b   : req0_b;
                        carry_q <= grant_id ? req1_cin : req0_cin;
                        id_q    <= grant_id;
                        idx_q   <= '0;
                    end
                end
                CALC: begin
                    sum_q[idx_q*NIBBLE_W +: NIBBLE_W] <= nib_s;
                    carry_q <= nib_c;
                    if (last_pass) begin
                        idx_q  <= '0;
                        cout_q <= nib_c;
                    end else begin
                        idx_q  <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rr_q <= id_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_shared_adder_sequencer.sv
module tb_shared_adder_sequencer;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             req0_cin = 1'b0, req1_cin = 1'b0;
    logic             rsp_valid, rsp_id, rsp_cout, busy;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_sum;

    shared_adder_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } exp_t;

    exp_t             sb[$];
    logic             rsp_ids[$];
    int unsigned      chk_cnt = 0, pass_cnt = 0;
    int unsigned      cyc = 0, acc_cyc = 0, rel_cyc = 0;
    logic             seen_valid = 1'b0, hold_pend = 1'b0;
    logic [WIDTH-1:0] hold_sum;
    logic             hold_id, hold_cout;
    logic [WIDTH:0]   mon_full;
    exp_t             mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Scoreboard: push the reference result on request accept, pop on response.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            seen_valid = 1'b0;
            hold_pend  = 1'b0;
        end else begin
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                check("ready_onehot", {63'd0, req0_ready && req1_ready}, 64'd0);
                if (req1_ready) begin
                    mon_full = {1'b0, req1_a} + {1'b0, req1_b} + (WIDTH+1)'(req1_cin);
                    mon_e.id = 1'b1;
                end else begin
                    mon_full = {1'b0, req0_a} + {1'b0, req0_b} + (WIDTH+1)'(req0_cin);
                    mon_e.id = 1'b0;
                end
                mon_e.sum  = mon_full[WIDTH-1:0];
                mon_e.cout = mon_full[WIDTH];
                sb.push_back(mon_e);
                acc_cyc = cyc;
            end
            if (busy) check("ready_in_busy", {62'd0, req0_ready, req1_ready}, 64'd0);
            if (rsp_valid) begin
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    check("latency", 64'(cyc - acc_cyc), 64'(NIB + 1));
                end
                if (hold_pend) begin
                    check("hold_sum",  64'(rsp_sum),  64'(hold_sum));
                    check("hold_id",   64'(rsp_id),   64'(hold_id));
                    check("hold_cout", 64'(rsp_cout), 64'(hold_cout));
                end
                if (rsp_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("sb_sum",  64'(rsp_sum),  64'(mon_e.sum));
                        check("sb_id",   64'(rsp_id),   64'(mon_e.id));
                        check("sb_cout", 64'(rsp_cout), 64'(mon_e.cout));
                    end
                    rsp_ids.push_back(rsp_id);
                    rel_cyc    = cyc;
                    seen_valid = 1'b0;
                    hold_pend  = 1'b0;
                end else begin
                    hold_pend = 1'b1;
                    hold_sum  = rsp_sum;
                    hold_id   = rsp_id;
                    hold_cout = rsp_cout;
                end
            end
        end
    end

    task automatic send(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin);
        int unsigned n;
        n = 0;
        if (id) begin req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1; end
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? req1_ready : req0_ready) && n < 200);
        if (!(id ? req1_ready : req0_ready)) begin
            check("send_timeout", 64'd1, 64'd0);
        end else begin
            @(posedge clk);
            #1;
        end
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [WIDTH-1:0] s, output logic id, output logic co);
        int unsigned n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rsp_valid && rsp_ready) && n < 200);
        if (!(rsp_valid && rsp_ready)) check("rsp_timeout", 64'd1, 64'd0);
        s  = rsp_sum;
        id = rsp_id;
        co = rsp_cout;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic directed(input string tag, input logic id, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic cin,
                            input logic [WIDTH-1:0] es, input logic ec);
        logic [WIDTH-1:0] s;
        logic             rid, co;
        send(id, a, b, cin);
        wait_rsp(s, rid, co);
        check({tag, "_sum"},  64'(s),   64'(es));
        check({tag, "_cout"}, 64'(co),  64'(ec));
        check({tag, "_id"},   64'(rid), 64'(id));
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"},
              {57'd0, rsp_valid, rsp_id, rsp_cout, busy, req0_ready, req1_ready, 1'b0},
              64'd0);
        check({tag, "_sum"}, 64'(rsp_sum), 64'd0);
    endtask

    initial begin
        int unsigned n;

        #1 rst_n = 1'b0;
        #2 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single requester, ripple and max-operand cases.
        directed("t1", 1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0);
        directed("t2", 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        directed("t3", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

        // Both requesters continuously valid: strict alternation starting at 0.
        do_reset();
        rsp_ids.delete();
        fork
            begin
                send(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
                send(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
            end
            begin
                send(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
                send(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            end
        join
        n = 0;
        while (rsp_ids.size() < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rr_count", 64'(rsp_ids.size()), 64'd4);
        for (int i = 0; i < 4 && i < rsp_ids.size(); i++)
            check("rr_seq", 64'(rsp_ids[i]), 64'(i % 2));

        // Backpressure with a second request waiting behind the held response.
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        fork
            send(1'b0, 16'h8421, 16'h7BDE, 1'b1);
            send(1'b1, 16'h0F0F, 16'hF0F1, 1'b0);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!rsp_valid && n < 200);
                check("bp_valid", 64'(rsp_valid), 64'd1);
                repeat (10) begin
                    @(negedge clk);
                    check("bp_busy",  64'(busy), 64'd1);
                    check("bp_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
                end
                @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        check("bp_next_accept", 64'(acc_cyc), 64'(rel_cyc + 1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rsp_valid && rsp_ready) && n < 200);
        check("bp_second_rsp", 64'(rsp_valid && rsp_id), 64'd1);
        @(posedge clk);
        #1;

        // Reset in the second CALC cycle aborts the in-flight add.
        send(1'b0, 16'h5555, 16'h3333, 1'b0);
        @(posedge clk);
        req1_a = 16'h00FF; req1_b = 16'h0001; req1_cin = 1'b0; req1_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_all_zero("abort");
        @(negedge clk);
        check("abort_ready_gated", {62'd0, req0_ready, req1_ready}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        directed("t6", 1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

        repeat (8) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("idle_end", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
